// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared widths, sample types and the round/saturate helper
package fir_pkg;

  localparam int ACC_W = 32;
  localparam int SMP_W = 16;

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic signed [SMP_W-1:0] smp_t;

  localparam smp_t SMP_MAX = 16'sh7FFF;
  localparam smp_t SMP_MIN = 16'sh8000;

  typedef struct packed {
    logic sat;
    smp_t smp;
  } narrow_t;

  // One guard bit above the accumulator keeps the rounding add from wrapping.
  function automatic narrow_t narrow(input acc_t acc, input int shift);
    logic        [ACC_W:0] rnd;
    logic signed [ACC_W:0] r;
    narrow_t               res;
    rnd = ({{ACC_W{1'b0}}, 1'b1} << shift) >> 1;
    r   = ($signed({acc[ACC_W-1], acc}) + $signed(rnd)) >>> shift;
    res.sat = 1'b0;
    res.smp = r[SMP_W-1:0];
    if (r > 33'sd32767) begin
      res.sat = 1'b1;
      res.smp = SMP_MAX;
    end else if (r < -33'sd32768) begin
      res.sat = 1'b1;
      res.smp = SMP_MIN;
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_out_quant_if.sv
// rtl/fir_out_quant_if.sv - sample input, buffered output handshake and status bundle
interface fir_out_quant_if;
  import fir_pkg::*;

  logic        in_valid;
  acc_t        in_data;
  logic        out_valid;
  logic        out_ready;
  smp_t        out_data;
  logic        clr_flags;
  logic        sat_flag;
  logic        ovf_flag;
  logic [15:0] drop_cnt;

  modport master (
    output in_valid, in_data, out_ready, clr_flags,
    input  out_valid, out_data, sat_flag, ovf_flag, drop_cnt
  );

  modport slave (
    input  in_valid, in_data, out_ready, clr_flags,
    output out_valid, out_data, sat_flag, ovf_flag, drop_cnt
  );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - pointer+count synchronous FIFO with show-ahead read
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign pop   = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
  assign push  = wr_en && (!full || pop);

  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/fir_out_quant.sv
// rtl/fir_out_quant.sv - round/saturate/narrow FIR output, decimate, buffer and report drops
module fir_out_quant
  import fir_pkg::*;
#(
  parameter int SHIFT = 15,
  parameter int DECIM = 1,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  fir_out_quant_if.slave bus
);

  narrow_t     nq;
  logic [7:0]  dcnt;
  logic        s1_valid;
  smp_t        s1_data;
  logic [SMP_W-1:0] head;
  logic        full;
  logic        empty;
  logic        sat_evt;
  logic        drop;
  logic        sat_q;
  logic        ovf_q;
  logic [15:0] drop_q;

  assign nq      = narrow(bus.in_data, SHIFT);
  assign sat_evt = bus.in_valid && nq.sat;

  always_ff @(posedge clk) begin
    if (!rst) begin
      dcnt     <= '0;
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= bus.in_valid && (dcnt == '0);
      if (bus.in_valid) begin
        s1_data <= nq.smp;
        dcnt    <= (dcnt == 8'(DECIM - 1)) ? '0 : dcnt + 8'd1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (SMP_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (s1_valid),
    .wr_data (s1_data),
    .rd_en   (bus.out_ready),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  // Full implies non-empty, so out_ready alone decides whether a slot frees up.
  assign drop = s1_valid && full && !bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sat_q  <= 1'b0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      if (sat_evt)             sat_q <= 1'b1;
      else if (bus.clr_flags)  sat_q <= 1'b0;
      if (drop)                ovf_q <= 1'b1;
      else if (bus.clr_flags)  ovf_q <= 1'b0;
      if (bus.clr_flags)       drop_q <= drop ? 16'd1 : 16'd0;
      else if (drop && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
    end
  end

  assign bus.out_valid = !empty;
  assign bus.out_data  = head;
  assign bus.sat_flag  = sat_q;
  assign bus.ovf_flag  = ovf_q;
  assign bus.drop_cnt  = drop_q;

endmodule

// File: tb/tb_fir_out_quant.sv
// tb/tb_fir_out_quant.sv - directed bench for fir_out_quant (DECIM=1 and DECIM=3 instances)
module tb_fir_out_quant;
  import fir_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  fir_out_quant_if a ();
  fir_out_quant_if b ();

  fir_out_quant #(.SHIFT(15), .DECIM(1), .DEPTH(4)) dut_a (.clk(clk), .rst(rst), .bus(a));
  fir_out_quant #(.SHIFT(15), .DECIM(3), .DEPTH(4)) dut_b (.clk(clk), .rst(rst), .bus(b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  task automatic send_a(input logic [31:0] d);
    a.in_valid = 1'b1;
    a.in_data  = d;
    @(negedge clk);
    a.in_valid = 1'b0;
  endtask

  task automatic pop_a(input string tag, input logic [15:0] exp);
    for (int n = 0; n < 20 && !a.out_valid; n++) @(negedge clk);
    check({tag, "_valid"}, {31'd0, a.out_valid}, 32'd1);
    check(tag, {16'h0, a.out_data}, {16'h0, exp});
    a.out_ready = 1'b1;
    @(negedge clk);
    a.out_ready = 1'b0;
  endtask

  task automatic pop_b(input string tag, input logic [15:0] exp);
    for (int n = 0; n < 20 && !b.out_valid; n++) @(negedge clk);
    check({tag, "_valid"}, {31'd0, b.out_valid}, 32'd1);
    check(tag, {16'h0, b.out_data}, {16'h0, exp});
    b.out_ready = 1'b1;
    @(negedge clk);
    b.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    a.in_valid = 1'b0; a.in_data = '0; a.out_ready = 1'b0; a.clr_flags = 1'b0;
    b.in_valid = 1'b0; b.in_data = '0; b.out_ready = 1'b0; b.clr_flags = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, a.out_valid}, 32'd0);
    check("rst_data", {16'h0, a.out_data}, 32'd0);
    check("rst_sat", {31'd0, a.sat_flag}, 32'd0);
    check("rst_ovf", {31'd0, a.ovf_flag}, 32'd0);
    check("rst_drop", {16'h0, a.drop_cnt}, 32'd0);
    rst = 1'b1;

    // rounding and two-cycle latency
    send_a(32'h0000_4000);
    check("lat_c1", {31'd0, a.out_valid}, 32'd0);
    @(negedge clk);
    check("lat_c2", {31'd0, a.out_valid}, 32'd1);
    pop_a("rnd_4000", 16'h0001);
    send_a(32'h0000_3FFF);
    send_a(32'hFFFF_C000);
    send_a(32'hFFFF_BFFF);
    pop_a("rnd_3fff", 16'h0000);
    pop_a("rnd_c000", 16'h0000);
    pop_a("rnd_bfff", 16'hFFFF);
    check("rnd_nosat", {31'd0, a.sat_flag}, 32'd0);

    // saturation and clear
    send_a(32'h4000_0000);
    check("sat_rise", {31'd0, a.sat_flag}, 32'd1);
    send_a(32'hBFFF_0000);
    pop_a("sat_pos", 16'h7FFF);
    pop_a("sat_neg", 16'h8000);
    check("sat_hold", {31'd0, a.sat_flag}, 32'd1);
    a.clr_flags = 1'b1;
    @(negedge clk);
    a.clr_flags = 1'b0;
    check("sat_clr", {31'd0, a.sat_flag}, 32'd0);

    // overflow: 6 kept samples into a 4-deep FIFO
    for (int v = 10; v < 16; v++) begin
      send_a(32'(v) << 15);
      if (v == 14) check("ovf_pre", {31'd0, a.ovf_flag}, 32'd0);
    end
    check("ovf_drop1", {16'h0, a.drop_cnt}, 32'd1);
    @(negedge clk);
    check("ovf_flag", {31'd0, a.ovf_flag}, 32'd1);
    check("ovf_drop2", {16'h0, a.drop_cnt}, 32'd2);
    pop_a("ovf_d10", 16'd10);
    pop_a("ovf_d11", 16'd11);
    pop_a("ovf_d12", 16'd12);
    pop_a("ovf_d13", 16'd13);
    check("ovf_empty", {31'd0, a.out_valid}, 32'd0);

    // write into a full FIFO in the same cycle as a pop
    for (int v = 20; v < 24; v++) send_a(32'(v) << 15);
    @(negedge clk);
    send_a(32'd24 << 15);
    check("fwp_head", {16'h0, a.out_data}, 32'd20);
    a.out_ready = 1'b1;
    @(negedge clk);
    a.out_ready = 1'b0;
    check("fwp_drop", {16'h0, a.drop_cnt}, 32'd2);
    pop_a("fwp_d21", 16'd21);
    pop_a("fwp_d22", 16'd22);
    pop_a("fwp_d23", 16'd23);
    pop_a("fwp_d24", 16'd24);
    check("fwp_empty", {31'd0, a.out_valid}, 32'd0);

    // saturation arriving together with clr_flags wins
    a.clr_flags = 1'b1;
    send_a(32'h4000_0000);
    a.clr_flags = 1'b0;
    check("clr_sat_win", {31'd0, a.sat_flag}, 32'd1);
    check("clr_ovf", {31'd0, a.ovf_flag}, 32'd0);
    check("clr_drop", {16'h0, a.drop_cnt}, 32'd0);
    pop_a("clr_d", 16'h7FFF);

    // decimation by 3
    for (int v = 1; v < 7; v++) begin
      b.in_valid = 1'b1;
      b.in_data  = 32'(v) << 15;
      @(negedge clk);
    end
    b.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    pop_b("dec_1", 16'd1);
    pop_b("dec_4", 16'd4);
    check("dec_empty", {31'd0, b.out_valid}, 32'd0);

    // reset mid-stream; b's counter is left at 1 before reset
    b.in_valid = 1'b1;
    b.in_data  = 32'd7 << 15;
    send_a(32'h4000_0000);
    b.in_valid = 1'b0;
    send_a(32'd30 << 15);
    send_a(32'd31 << 15);
    repeat (2) @(negedge clk);
    check("mr_pre_valid", {31'd0, a.out_valid}, 32'd1);
    check("mr_pre_sat", {31'd0, a.sat_flag}, 32'd1);
    check("mr_pre_b", {31'd0, b.out_valid}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("mr_valid", {31'd0, a.out_valid}, 32'd0);
    check("mr_data", {16'h0, a.out_data}, 32'd0);
    check("mr_sat", {31'd0, a.sat_flag}, 32'd0);
    check("mr_ovf", {31'd0, a.ovf_flag}, 32'd0);
    check("mr_drop", {16'h0, a.drop_cnt}, 32'd0);
    check("mr_b_valid", {31'd0, b.out_valid}, 32'd0);
    b.in_valid = 1'b1;
    b.in_data  = 32'd9 << 15;
    send_a(32'd40 << 15);
    b.in_valid = 1'b0;
    @(negedge clk);
    pop_a("mr_a_first", 16'd40);
    pop_b("mr_b_first", 16'd9);
    check("mr_a_empty", {31'd0, a.out_valid}, 32'd0);
    check("mr_b_empty", {31'd0, b.out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
